// File: rtl/if_stage_pkg.sv
// -----------------------------------------------------------------------------
// if_stage_pkg
// Shared constants and types for the instruction-fetch stage.
//   RESET_PC_DEFAULT : default first fetch address after reset
//   if_state_e       : fetch FSM state encoding
// -----------------------------------------------------------------------------
package if_stage_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h1C00_0000;

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,   // presenting a fetch request
      S_WAIT = 2'd1,   // request accepted, waiting for data
      S_DROP = 2'd2,   // response still in flight but must be thrown away
      S_FULL = 2'd3    // data arrived while stalled, parked in hold buffer
   } if_state_e;

endpackage

// File: rtl/if_id_reg.sv
// -----------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register with flush / load / hold / bubble behaviour.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   i_flush      : redirect; invalidates the register (highest priority)
//   i_load       : capture i_pc / i_inst as a valid instruction
//   i_stall      : hold current contents
//   i_pc, i_inst : PC and instruction to capture
//   o_id_pc, o_id_inst, o_id_valid : register contents
// -----------------------------------------------------------------------------
module if_id_reg (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_flush,
   input  logic        i_load,
   input  logic        i_stall,
   input  logic [31:0] i_pc,
   input  logic [31:0] i_inst,
   output logic [31:0] o_id_pc,
   output logic [31:0] o_id_inst,
   output logic        o_id_valid
);

   logic [31:0] r_pc;
   logic [31:0] r_inst;
   logic        r_valid;

   // IF/ID register: flush beats load beats stall; otherwise insert a bubble
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc    <= 32'h0000_0000;
         r_inst  <= 32'h0000_0000;
         r_valid <= 1'b0;
      end else if (i_flush) begin
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_pc    <= i_pc;
         r_inst  <= i_inst;
         r_valid <= 1'b1;
      end else if (i_stall) begin
         r_valid <= r_valid;
      end else begin
         r_valid <= 1'b0;
      end
   end

   assign o_id_pc    = r_pc;
   assign o_id_inst  = r_inst;
   assign o_id_valid = r_valid;

endmodule

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage
// Instruction-fetch stage: one outstanding fetch, PC register, hold buffer
// for data that arrives while the pipeline is stalled, and the IF/ID register.
// Ports:
//   cpu_clk, cpu_rst            : clock, synchronous active-high reset
//   npc, jump_taken, stall      : next PC, redirect, hazard hold
//   inst_req, inst_addr         : fetch request / address (= if_pc)
//   inst_ack, inst_rvalid,
//   inst_rdata                  : request accept, data valid, data
//   if_pc                       : current fetch PC
//   id_pc, id_inst, id_valid    : IF/ID register contents
// -----------------------------------------------------------------------------
module if_stage
   import if_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        cpu_clk,
   input  logic        cpu_rst,
   input  logic [31:0] npc,
   input  logic        jump_taken,
   input  logic        stall,
   output logic        inst_req,
   output logic [31:0] inst_addr,
   input  logic        inst_ack,
   input  logic        inst_rvalid,
   input  logic [31:0] inst_rdata,
   output logic [31:0] if_pc,
   output logic [31:0] id_pc,
   output logic [31:0] id_inst,
   output logic        id_valid
);

   if_state_e   r_state;
   if_state_e   w_state_nxt;
   logic [31:0] r_pc;
   logic [31:0] r_buf;
   logic        w_pc_load;    // if_pc <= npc
   logic        w_id_load;    // capture into IF/ID
   logic        w_id_from_buf;
   logic        w_buf_load;
   logic [31:0] w_id_inst;

   // State, PC and hold-buffer registers
   always_ff @(posedge cpu_clk) begin
      if (cpu_rst) begin
         r_state <= S_REQ;
         r_pc    <= RESET_PC;
         r_buf   <= 32'h0000_0000;
      end else begin
         r_state <= w_state_nxt;
         if (w_pc_load) begin
            r_pc <= npc;
         end
         if (w_buf_load) begin
            r_buf <= inst_rdata;
         end
      end
   end

   // Next-state and control decode; a jump always wins over stall
   always_comb begin
      w_state_nxt   = r_state;
      w_pc_load     = 1'b0;
      w_id_load     = 1'b0;
      w_id_from_buf = 1'b0;
      w_buf_load    = 1'b0;
      case (r_state)
         S_REQ: begin
            if (jump_taken) begin
               w_pc_load   = 1'b1;
               // an accepted request to the old PC must be discarded
               w_state_nxt = inst_ack ? S_DROP : S_REQ;
            end else if (inst_ack) begin
               w_state_nxt = S_WAIT;
            end else begin
               w_state_nxt = S_REQ;
            end
         end
         S_WAIT: begin
            if (jump_taken) begin
               w_pc_load   = 1'b1;
               w_state_nxt = inst_rvalid ? S_REQ : S_DROP;
            end else if (inst_rvalid) begin
               if (stall) begin
                  w_buf_load  = 1'b1;
                  w_state_nxt = S_FULL;
               end else begin
                  w_id_load   = 1'b1;
                  w_pc_load   = 1'b1;
                  w_state_nxt = S_REQ;
               end
            end else begin
               w_state_nxt = S_WAIT;
            end
         end
         S_DROP: begin
            w_pc_load   = jump_taken;
            w_state_nxt = inst_rvalid ? S_REQ : S_DROP;
         end
         S_FULL: begin
            if (jump_taken) begin
               w_pc_load   = 1'b1;
               w_state_nxt = S_REQ;
            end else if (!stall) begin
               w_id_load     = 1'b1;
               w_id_from_buf = 1'b1;
               w_pc_load     = 1'b1;
               w_state_nxt   = S_REQ;
            end else begin
               w_state_nxt = S_FULL;
            end
         end
         default: begin
            w_state_nxt = S_REQ;
         end
      endcase
   end

   assign w_id_inst = w_id_from_buf ? r_buf : inst_rdata;

   if_id_reg u_if_id_reg (
      .clk        (cpu_clk),
      .rst        (cpu_rst),
      .i_flush    (jump_taken),
      .i_load     (w_id_load),
      .i_stall    (stall),
      .i_pc       (r_pc),
      .i_inst     (w_id_inst),
      .o_id_pc    (id_pc),
      .o_id_inst  (id_inst),
      .o_id_valid (id_valid)
   );

   assign inst_req  = (r_state == S_REQ);
   assign inst_addr = r_pc;
   assign if_pc     = r_pc;

endmodule

// File: tb/tb_if_stage.sv
// -----------------------------------------------------------------------------
// tb_if_stage
// Directed bench for if_stage. Expected IF/ID contents are queued as stimulus
// is issued; a monitor pops and compares whenever a new instruction appears.
// -----------------------------------------------------------------------------
module tb_if_stage;

   logic        cpu_clk;
   logic        cpu_rst;
   logic [31:0] npc;
   logic        jump_taken;
   logic        stall;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_ack;
   logic        inst_rvalid;
   logic [31:0] inst_rdata;
   logic [31:0] if_pc;
   logic [31:0] id_pc;
   logic [31:0] id_inst;
   logic        id_valid;

   logic [31:0] tgt;
   logic        stall_at_edge;
   logic        jump_at_edge;
   logic        rst_at_edge;

   int n_vec = 0;
   int n_bad = 0;
   logic [63:0] exp_q [$];

   if_stage #(.RESET_PC(32'h1C00_0000)) dut (
      .cpu_clk     (cpu_clk),
      .cpu_rst     (cpu_rst),
      .npc         (npc),
      .jump_taken  (jump_taken),
      .stall       (stall),
      .inst_req    (inst_req),
      .inst_addr   (inst_addr),
      .inst_ack    (inst_ack),
      .inst_rvalid (inst_rvalid),
      .inst_rdata  (inst_rdata),
      .if_pc       (if_pc),
      .id_pc       (id_pc),
      .id_inst     (id_inst),
      .id_valid    (id_valid)
   );

   initial begin
      cpu_clk = 1'b0;
      forever #5 cpu_clk = ~cpu_clk;
   end

   // NPC stage stand-in: sequential PC or the jump target
   assign npc = jump_taken ? tgt : (if_pc + 32'd4);

   always @(posedge cpu_clk) begin
      stall_at_edge <= stall;
      jump_at_edge  <= jump_taken;
      rst_at_edge   <= cpu_rst;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec = n_vec + 1;
      if (act !== exp) begin
         n_bad = n_bad + 1;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: a freshly loaded instruction is visible when id_valid is high
   // and the preceding edge was neither a stall, a jump nor a reset.
   always @(negedge cpu_clk) begin
      if (id_valid === 1'b1 && stall_at_edge === 1'b0 &&
          jump_at_edge === 1'b0 && rst_at_edge === 1'b0) begin
         logic [63:0] e;
         n_vec = n_vec + 1;
         if (exp_q.size() == 0) begin
            n_bad = n_bad + 1;
            $display("FAIL unexpected_id: got pc %h inst %h expected none", id_pc, id_inst);
         end else begin
            e = exp_q.pop_front();
            if ({id_pc, id_inst} !== e) begin
               n_bad = n_bad + 1;
               $display("FAIL id_pair: got pc %h inst %h expected pc %h inst %h",
                        id_pc, id_inst, e[63:32], e[31:0]);
            end
         end
      end
   end

   task automatic cyc(input logic rst, input logic ack, input logic rv,
                      input logic [31:0] rd, input logic jmp,
                      input logic [31:0] t, input logic stl);
      cpu_rst     = rst;
      inst_ack    = ack;
      inst_rvalid = rv;
      inst_rdata  = rd;
      jump_taken  = jmp;
      tgt         = t;
      stall       = stl;
      @(posedge cpu_clk);
      #1;
   endtask

   // fetch cycle pair: ack in S_REQ, then data in S_WAIT with no stall
   task automatic fetch(input logic [31:0] exp_pc, input logic [31:0] rd);
      cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      exp_q.push_back({exp_pc, rd});
      cyc(1'b0, 1'b0, 1'b1, rd, 1'b0, 32'h0, 1'b0);
   endtask

   initial begin
      // reset
      cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      chk("rst_inst_req",  {31'd0, inst_req}, 32'd1);
      chk("rst_inst_addr", inst_addr, 32'h1C00_0000);
      chk("rst_id_valid",  {31'd0, id_valid}, 32'd0);
      chk("rst_id_pc",     id_pc,     32'h0000_0000);
      chk("rst_id_inst",   id_inst,   32'h0000_0000);

      // straight-line fetches, rdata = PC
      fetch(32'h1C00_0000, 32'h1C00_0000);
      fetch(32'h1C00_0004, 32'h1C00_0004);
      fetch(32'h1C00_0008, 32'h1C00_0008);
      chk("seq_if_pc", if_pc, 32'h1C00_000C);

      // stall held across ack, data arrival and two more cycles
      cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      chk("stall_hold_valid", {31'd0, id_valid}, 32'd1);
      cyc(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      chk("full_id_pc",    id_pc,   32'h1C00_0008);
      chk("full_id_inst",  id_inst, 32'h1C00_0008);
      chk("full_id_valid", {31'd0, id_valid}, 32'd1);
      chk("full_no_req",   {31'd0, inst_req}, 32'd0);
      chk("full_if_pc",    if_pc,   32'h1C00_000C);
      exp_q.push_back({32'h1C00_000C, 32'hDEAD_BEEF});
      cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      chk("release_if_pc", if_pc, 32'h1C00_0010);
      chk("release_req",   {31'd0, inst_req}, 32'd1);

      // jump in S_WAIT, response arrives two cycles later and is dropped
      cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h1C00_0100, 1'b0);
      chk("jw_id_valid", {31'd0, id_valid}, 32'd0);
      cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      chk("jw_drop_no_req", {31'd0, inst_req}, 32'd0);
      cyc(1'b0, 1'b0, 1'b1, 32'hBAD0_0001, 1'b0, 32'h0, 1'b0);
      chk("jw_id_valid2", {31'd0, id_valid}, 32'd0);
      chk("jw_req",       {31'd0, inst_req}, 32'd1);
      chk("jw_addr",      inst_addr, 32'h1C00_0100);
      fetch(32'h1C00_0100, 32'h1111_1111);

      // jump together with ack in S_REQ
      cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h1C00_0200, 1'b0);
      chk("ja_no_req", {31'd0, inst_req}, 32'd0);
      chk("ja_addr",   inst_addr, 32'h1C00_0200);
      cyc(1'b0, 1'b0, 1'b1, 32'hBAD0_0002, 1'b0, 32'h0, 1'b0);
      chk("ja_req",      {31'd0, inst_req}, 32'd1);
      chk("ja_id_valid", {31'd0, id_valid}, 32'd0);
      fetch(32'h1C00_0200, 32'h2222_2222);

      // stray rvalid in S_REQ is ignored
      cyc(1'b0, 1'b0, 1'b1, 32'hBAD0_0003, 1'b0, 32'h0, 1'b0);
      chk("stray_req",   {31'd0, inst_req}, 32'd1);
      chk("stray_if_pc", if_pc, 32'h1C00_0204);

      // jump and stall together in S_FULL
      cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 32'h3333_3333, 1'b0, 32'h0, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h1C00_0300, 1'b1);
      chk("jf_if_pc",    if_pc, 32'h1C00_0300);
      chk("jf_id_valid", {31'd0, id_valid}, 32'd0);
      chk("jf_req",      {31'd0, inst_req}, 32'd1);
      fetch(32'h1C00_0300, 32'h4444_4444);

      // reset pulsed while waiting for data
      cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      chk("rw_req",      {31'd0, inst_req}, 32'd1);
      chk("rw_addr",     inst_addr, 32'h1C00_0000);
      chk("rw_id_valid", {31'd0, id_valid}, 32'd0);
      chk("rw_id_pc",    id_pc, 32'h0000_0000);
      cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      fetch(32'h1C00_0000, 32'h5555_5555);
      cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

      chk("queue_drained", exp_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
